ntt_butterfly: RTL and testbench

- Pipelined NTT/INTT butterfly for the Kyber polynomial datapath (q = 3329, R = 2^16).
- Consumes a coefficient pair plus a twiddle and forms the 32-bit zeta product for the Montgomery reduction stage.
- Consumes the reduced 16-bit result to emit the butterfly outputs.
- Forward mode is Cooley-Tukey and inverse mode is Gentleman-Sande. Reductions are computed inline, bit-exact to the reference C (montgomery_reduce, barrett_reduce). Fully pipelined with valid/ready flow control.

---
 rtl/ntt_butterfly.sv | 121 ++++++++++++
 tb/tb_ntt_butterfly.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly.sv
// Kyber NTT/INTT butterfly (CT fwd, GS inv) with inline Montgomery/Barrett; 3-clk latency, 1 beat/clk.
// Backpressure: global stall freezes all stages while out_valid & ~out_ready; in_ready = ~stall.
module ntt_butterfly #(
  parameter int Q         = 3329,
  parameter int QINV      = -3327,
  parameter int BARRETT_V = 20159,
  parameter int TAG_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [15:0]      a,
  input  logic signed [15:0]      b,
  input  logic signed [15:0]      zeta,
  input  logic [TAG_W-1:0]        tag_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_lo,
  output logic signed [15:0]      out_hi,
  output logic [TAG_W-1:0]        tag_out
);

  localparam logic signed [31:0] Q32    = Q;
  localparam logic signed [31:0] BV32   = BARRETT_V;
  localparam logic signed [31:0] BROUND = 32'sd33554432;
  localparam logic [15:0]        QINV16 = 16'(QINV);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // S1 inputs: GS pre-combines the pair, CT multiplies b directly
  logic signed [15:0] sum_ab, dif_ba, mul_op;
  logic signed [31:0] zeta_ext, op_ext, p_in;
  assign sum_ab   = a + b;
  assign dif_ba   = b - a;
  assign mul_op   = mode ? dif_ba : b;
  assign zeta_ext = {{16{zeta[15]}}, zeta};
  assign op_ext   = {{16{mul_op[15]}}, mul_op};
  assign p_in     = zeta_ext * op_ext;

  logic               v1, mode1;
  logic [TAG_W-1:0]   tag1;
  logic signed [31:0] p1;
  logic signed [15:0] x1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      mode1 <= 1'b0;
      tag1  <= '0;
      p1    <= '0;
      x1    <= '0;
    end else if (!stall) begin
      v1    <= in_valid;
      mode1 <= mode;
      tag1  <= tag_in;
      p1    <= p_in;
      x1    <= mode ? sum_ab : a;
    end
  end

  // S2: Montgomery reduction of the product; low 16 bits of t are zero by construction
  logic [15:0]        u16;
  logic signed [31:0] u_ext, t_full, m_red32;
  logic signed [15:0] m_red;
  assign u16     = p1[15:0] * QINV16;
  assign u_ext   = {{16{u16[15]}}, u16};
  assign t_full  = p1 - u_ext * Q32;
  assign m_red32 = t_full >>> 16;
  assign m_red   = 16'(m_red32);

  logic signed [31:0] x1_ext, bk_full, k_full, kq_full;
  logic signed [15:0] r_red;
  assign x1_ext  = {{16{x1[15]}}, x1};
  assign bk_full = BV32 * x1_ext + BROUND;
  assign k_full  = bk_full >>> 26;
  assign kq_full = k_full * Q32;
  assign r_red   = x1 - 16'(kq_full);

  logic               v2, mode2;
  logic [TAG_W-1:0]   tag2;
  logic signed [15:0] m2, x2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      mode2 <= 1'b0;
      tag2  <= '0;
      m2    <= '0;
      x2    <= '0;
    end else if (!stall) begin
      v2    <= v1;
      mode2 <= mode1;
      tag2  <= tag1;
      m2    <= m_red;
      x2    <= mode1 ? r_red : x1;
    end
  end

  logic signed [15:0] lo_nxt, hi_nxt;
  assign lo_nxt = mode2 ? x2 : x2 + m2;
  assign hi_nxt = mode2 ? m2 : x2 - m2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      tag_out   <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      out_lo    <= lo_nxt;
      out_hi    <= hi_nxt;
      tag_out   <= tag2;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: directed vectors, backpressure, random traffic, mid-stream reset.
module tb_ntt_butterfly;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, mode, out_valid, out_ready;
  logic signed [15:0] a, b, zeta, out_lo, out_hi;
  logic [7:0]         tag_in, tag_out;

  ntt_butterfly dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .zeta(zeta), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lo;
    int hi;
    int tag;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold_ready = 1'b0;
  bit   rand_ready = 1'b0;
  bit   lat_mode   = 1'b0;

  // Reference arithmetic on plain integers
  function automatic int wrap16(input int x);
    int w;
    w = x & 32'h0000ffff;
    if (w >= 32768) w = w - 65536;
    return w;
  endfunction

  function automatic int mont(input int p);
    int u, t;
    u = wrap16(wrap16(p) * (-3327));
    t = p - u * 3329;
    return wrap16(t / 65536);
  endfunction

  function automatic int barrett(input int s);
    int k;
    k = (20159 * s + (1 << 25)) >>> 26;
    return wrap16(s - k * 3329);
  endfunction

  function automatic void model(input bit m, input int va, input int vb, input int vz,
                                output int lo, output int hi);
    int mm;
    if (!m) begin
      mm = mont(vz * vb);
      lo = wrap16(va + mm);
      hi = wrap16(va - mm);
    end else begin
      lo = barrett(wrap16(va + vb));
      hi = mont(vz * wrap16(vb - va));
    end
  endfunction

  function automatic int r16();
    logic signed [15:0] v;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: v = 16'sh8000;
      1: v = 16'sh7fff;
      2: v = 16'sd3329;
      3: v = -16'sd3329;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input bit m, input int va, input int vb, input int vz, input int t,
                          input bit use_exp, input int elo, input int ehi);
    exp_t e;
    int lo, hi;
    if (use_exp) begin
      lo = elo;
      hi = ehi;
    end else begin
      model(m, va, vb, vz, lo, hi);
    end
    e.lo  = lo;
    e.hi  = hi;
    e.tag = t;
    e.acc = cyc;
    e.lat = lat_mode;
    sb.push_back(e);
  endtask

  task automatic drive(input bit m, input int va, input int vb, input int vz, input int t);
    in_valid = 1'b1;
    mode     = m;
    a        = 16'(va);
    b        = 16'(vb);
    zeta     = 16'(vz);
    tag_in   = 8'(t);
  endtask

  task automatic send(input bit m, input int va, input int vb, input int vz, input int t,
                      input bit use_exp, input int elo, input int ehi);
    int n;
    n = 0;
    @(negedge clk);
    drive(m, va, vb, vz, t);
    #1;
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    push_exp(m, va, vb, vz, t, use_exp, elo, ehi);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic ready_drv();
    forever begin
      @(negedge clk);
      if (hold_ready)      out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit   pst;
    int   plo, phi, ptag;
    pst = 1'b0;
    plo = 0; phi = 0; ptag = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pst = 1'b0;
        continue;
      end
      if (pst) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_lo", int'(out_lo), plo);
        check("stall_hi", int'(out_hi), phi);
        check("stall_tag", int'(tag_out), ptag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat_tag", int'(tag_out), -1);
        end else begin
          e = sb.pop_front();
          check("out_tag", int'(tag_out), e.tag);
          check("out_lo", int'(out_lo), e.lo);
          check("out_hi", int'(out_hi), e.hi);
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
      pst  = out_valid && !out_ready;
      plo  = out_lo;
      phi  = out_hi;
      ptag = tag_out;
    end
  endtask

  task automatic stimulus();
    int nacc, nxt, n, ra, rb, rz;
    bit rm;

    // Reset state
    #22;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_lo", int'(out_lo), 0);
    check("rst_out_hi", int'(out_hi), 0);
    check("rst_tag_out", int'(tag_out), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Directed vectors, no stalls, latency checked
    lat_mode = 1'b1;
    send(1'b0,   100,     0,  1234, 11, 1'b1,    100,   100);
    send(1'b0,    10,   256,   256, 12, 1'b1,     11,     9);
    send(1'b0,    10,   256,  -256, 13, 1'b1,      9,    11);
    send(1'b0, 32767,   256,   256, 14, 1'b1, -32768, 32766);
    send(1'b1,  1000,  2329,     0, 15, 1'b1,      0,     0);
    send(1'b1, -1000, -2329,     0, 16, 1'b1,      0,     0);
    send(1'b1,  1234,  -567,  2000, 17, 1'b0,      0,     0);
    send(1'b0,  -300,  3000, -1500, 18, 1'b0,      0,     0);
    drain();

    // Backpressure: 5 beats offered against a blocked output
    lat_mode   = 1'b0;
    hold_ready = 1'b1;
    nacc = 0;
    nxt  = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rm = 1'($urandom); ra = r16(); rb = r16(); rz = r16();
      drive(rm, ra, rb, rz, nxt);
      #1;
      if (in_ready) begin
        push_exp(rm, ra, rb, rz, nxt, 1'b0, 0, 0);
        nxt++;
        nacc++;
      end
    end
    check("bp_accepted", nacc, 3);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_head_tag", int'(tag_out), 1);
    hold_ready = 1'b0;
    n = 0;
    while (nxt <= 5 && n < 50) begin
      @(negedge clk);
      rm = 1'($urandom); ra = r16(); rb = r16(); rz = r16();
      drive(rm, ra, rb, rz, nxt);
      #1;
      if (in_ready) begin
        push_exp(rm, ra, rb, rz, nxt, 1'b0, 0, 0);
        nxt++;
      end
      n++;
    end
    check("bp_all_accepted", nxt, 6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Random mixed-mode traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(1'($urandom), r16(), r16(), r16(), i & 255, 1'b0, 0, 0);
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with three beats in flight
    lat_mode = 1'b1;
    send(1'b0, 10, 256, 256, 101, 1'b0, 0, 0);
    send(1'b1, 1000, 2329, 77, 102, 1'b0, 0, 0);
    send(1'b0, 5, 5, 5, 103, 1'b0, 0, 0);
    check("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_tag", int'(tag_out), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #2;
      check("post_rst_quiet", int'(out_valid), 0);
    end
    send(1'b0, 10, 256, -256, 200, 1'b1, 9, 11);
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b0;
    a         = '0;
    b         = '0;
    zeta      = '0;
    tag_in    = '0;
    fork
      ready_drv();
      monitor();
      stimulus();
      begin
        #500000;
        check("global_timeout", 0, 1);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
